// File: rtl/pg_unit_ctrlr_if.sv
// Issue-stage <-> power-gating controller bundle: per-unit requests in, power/isolation/ready and stall out.
// The hint_i_pguc member exists only when PG_PREWAKE_EN is defined.
interface pg_unit_ctrlr_if #(
  parameter int unsigned NUM_UNITS = 2
);
  logic                 ins_vld_i_pguc;
  logic [NUM_UNITS-1:0] unit_req_i_pguc;
`ifdef PG_PREWAKE_EN
  logic [NUM_UNITS-1:0] hint_i_pguc;
`endif
  logic [NUM_UNITS-1:0] pwr_en_o_pguc;
  logic [NUM_UNITS-1:0] iso_en_o_pguc;
  logic [NUM_UNITS-1:0] unit_rdy_o_pguc;
  logic                 stall_o_pguc;

  // Issue stage side: drives requests, consumes gating status and stall.
  modport master (
    output ins_vld_i_pguc,
    output unit_req_i_pguc,
`ifdef PG_PREWAKE_EN
    output hint_i_pguc,
`endif
    input  pwr_en_o_pguc,
    input  iso_en_o_pguc,
    input  unit_rdy_o_pguc,
    input  stall_o_pguc
  );

  // Controller side.
  modport slave (
    input  ins_vld_i_pguc,
    input  unit_req_i_pguc,
`ifdef PG_PREWAKE_EN
    input  hint_i_pguc,
`endif
    output pwr_en_o_pguc,
    output iso_en_o_pguc,
    output unit_rdy_o_pguc,
    output stall_o_pguc
  );
endinterface

// File: rtl/pg_unit_ctrlr.sv
// Power-gating controller: each unit sequences ON -> ISO -> OFF on idleness and OFF -> WAKE -> ON on demand.
// Optional macro PG_PREWAKE_EN adds a fetch-stage hint that wakes units one stage early without stalling.
module pg_unit_ctrlr #(
  parameter int unsigned NUM_UNITS = 2,
  parameter int unsigned IDLE_TH   = 8,
  parameter int unsigned IDLE_W    = 4,
  parameter int unsigned WAKE_LAT  = 3,
  parameter int unsigned WAKE_W    = 2
) (
  input  logic            clk_i_pguc,
  input  logic            rst_i_pguc,
  pg_unit_ctrlr_if.slave  pg
);

  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TH - 1);
  localparam logic [IDLE_W-1:0] IDLE_SAT  = IDLE_W'(IDLE_TH);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_LAT - 1);

  typedef enum logic [1:0] {
    ST_ON   = 2'd0,
    ST_ISO  = 2'd1,
    ST_OFF  = 2'd2,
    ST_WAKE = 2'd3
  } state_t;

  state_t              state_q [NUM_UNITS];
  state_t              state_d [NUM_UNITS];
  logic [IDLE_W-1:0]   idle_q  [NUM_UNITS];
  logic [IDLE_W-1:0]   idle_d  [NUM_UNITS];
  logic [WAKE_W-1:0]   wake_q  [NUM_UNITS];
  logic [WAKE_W-1:0]   wake_d  [NUM_UNITS];

  logic [NUM_UNITS-1:0] req;
  logic [NUM_UNITS-1:0] demand;
  logic [NUM_UNITS-1:0] pwr_d;
  logic [NUM_UNITS-1:0] iso_d;
  logic [NUM_UNITS-1:0] rdy_d;
  logic [NUM_UNITS-1:0] pwr_q;
  logic [NUM_UNITS-1:0] iso_q;
  logic [NUM_UNITS-1:0] rdy_q;

  assign req = {NUM_UNITS{pg.ins_vld_i_pguc}} & pg.unit_req_i_pguc;

  // demand keeps a unit alive / wakes it; only real requests can stall.
`ifdef PG_PREWAKE_EN
  assign demand = req | pg.hint_i_pguc;
`else
  assign demand = req;
`endif

  // Next-state, counters and the output decode of the next state.
  always_comb begin
    for (int u = 0; u < NUM_UNITS; u++) begin
      state_d[u] = state_q[u];
      idle_d[u]  = idle_q[u];
      wake_d[u]  = wake_q[u];
      pwr_d[u]   = 1'b1;
      iso_d[u]   = 1'b0;
      rdy_d[u]   = 1'b1;

      case (state_q[u])
        ST_ON: begin
          if (demand[u]) begin
            idle_d[u] = '0;
          end else if (idle_q[u] == IDLE_LAST) begin
            state_d[u] = ST_ISO;
            idle_d[u]  = '0;
          end else if (idle_q[u] < IDLE_SAT) begin
            idle_d[u] = idle_q[u] + IDLE_W'(1);
          end
        end
        ST_ISO: begin
          // Power was never dropped, so a late request simply reopens the unit.
          state_d[u] = demand[u] ? ST_ON : ST_OFF;
        end
        ST_OFF: begin
          if (demand[u]) begin
            state_d[u] = ST_WAKE;
            wake_d[u]  = '0;
          end
        end
        ST_WAKE: begin
          // Wake always runs to completion so the power rail settles before de-isolation.
          if (wake_q[u] == WAKE_LAST) begin
            state_d[u] = ST_ON;
            idle_d[u]  = '0;
            wake_d[u]  = '0;
          end else begin
            wake_d[u] = wake_q[u] + WAKE_W'(1);
          end
        end
        default: begin
          state_d[u] = ST_ON;
          idle_d[u]  = '0;
          wake_d[u]  = '0;
        end
      endcase

      case (state_d[u])
        ST_ON: begin
          pwr_d[u] = 1'b1;
          iso_d[u] = 1'b0;
          rdy_d[u] = 1'b1;
        end
        ST_OFF: begin
          pwr_d[u] = 1'b0;
          iso_d[u] = 1'b1;
          rdy_d[u] = 1'b0;
        end
        default: begin
          pwr_d[u] = 1'b1;
          iso_d[u] = 1'b1;
          rdy_d[u] = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered status outputs.
  always_ff @(posedge clk_i_pguc) begin
    if (rst_i_pguc) begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        state_q[u] <= ST_ON;
        idle_q[u]  <= '0;
        wake_q[u]  <= '0;
      end
      pwr_q <= '1;
      iso_q <= '0;
      rdy_q <= '1;
    end else begin
      for (int u = 0; u < NUM_UNITS; u++) begin
        state_q[u] <= state_d[u];
        idle_q[u]  <= idle_d[u];
        wake_q[u]  <= wake_d[u];
      end
      pwr_q <= pwr_d;
      iso_q <= iso_d;
      rdy_q <= rdy_d;
    end
  end

  assign pg.pwr_en_o_pguc   = pwr_q;
  assign pg.iso_en_o_pguc   = iso_q;
  assign pg.unit_rdy_o_pguc = rdy_q;
  assign pg.stall_o_pguc    = |(req & ~rdy_q);

endmodule

// File: tb/tb_pg_unit_ctrlr.sv
// Scoreboard bench for pg_unit_ctrlr: per-cycle expected {pwr,iso,rdy,stall} queued with stimulus, checked at negedge.
// The prewake phase runs only when PG_PREWAKE_EN is defined.
module tb_pg_unit_ctrlr;

  typedef struct {
    string      tag;
    logic [6:0] exp;
  } sb_entry_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  sb_entry_t sb [$];
`ifdef PG_PREWAKE_EN
  logic [1:0] hint_nxt;
`endif

  pg_unit_ctrlr_if #(.NUM_UNITS(2)) pg ();

  pg_unit_ctrlr #(
    .NUM_UNITS (2),
    .IDLE_TH   (8),
    .IDLE_W    (4),
    .WAKE_LAT  (3),
    .WAKE_W    (2)
  ) dut (
    .clk_i_pguc (clk),
    .rst_i_pguc (rst),
    .pg         (pg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [6:0] got, input logic [6:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got pwr/iso/rdy/stall=%b_%b_%b_%b expected %b_%b_%b_%b",
               tag, got[6:5], got[4:3], got[2:1], got[0], exp[6:5], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  // Drive n cycles of stimulus, queue the expected outputs for each, compare at the falling edge.
  task automatic run(input int n, input logic r, input logic v, input logic [1:0] q,
                     input logic [1:0] pwr, input logic [1:0] iso, input logic [1:0] rdy,
                     input logic st, input string tag);
    sb_entry_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = r;
      pg.ins_vld_i_pguc  = v;
      pg.unit_req_i_pguc = q;
`ifdef PG_PREWAKE_EN
      pg.hint_i_pguc = hint_nxt;
`endif
      e.tag = tag;
      e.exp = {pwr, iso, rdy, st};
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        check_eq("sb_empty", 7'h7f, 7'h00);
      end else begin
        e = sb.pop_front();
        check_eq(e.tag, {pg.pwr_en_o_pguc, pg.iso_en_o_pguc, pg.unit_rdy_o_pguc, pg.stall_o_pguc}, e.exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    pg.ins_vld_i_pguc  = 1'b0;
    pg.unit_req_i_pguc = 2'b00;
`ifdef PG_PREWAKE_EN
    hint_nxt = 2'b00;
    pg.hint_i_pguc = 2'b00;
`endif
    repeat (2) @(posedge clk);

    // Reset and idle gating of both units.
    run(1, 1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, "reset");
    run(8, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, "idle_on");
    run(1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b11, 2'b00, 1'b0, "iso_both");
    run(1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, "off_both");

    // Wake unit 0 from OFF: stall WAKE_LAT+1 cycles.
    run(1, 1'b0, 1'b1, 2'b01, 2'b00, 2'b11, 2'b00, 1'b1, "wake_req");
    run(3, 1'b0, 1'b1, 2'b01, 2'b01, 2'b11, 2'b00, 1'b1, "wake_u0");
    run(1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b0, "wake_done");

    // Request exactly in ISO: one stall cycle, power never dropped.
    run(8, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b01, 1'b0, "u0_idle");
    run(1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b11, 2'b00, 1'b1, "iso_abort");
    run(1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b0, "iso_back_on");

    // Both OFF, parallel wake.
    run(8, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b01, 1'b0, "u0_idle2");
    run(1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b11, 2'b00, 1'b0, "u0_iso");
    run(1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, "all_off");
    run(1, 1'b0, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 1'b1, "par_req");
    run(3, 1'b0, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1, "par_wake");
    run(1, 1'b0, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 1'b0, "par_on");

    // Unit 1 requested every 7th cycle stays ON; unit 0 gates.
    run(6, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, "u1_keep");
    run(1, 1'b0, 1'b1, 2'b10, 2'b11, 2'b00, 2'b11, 1'b0, "u1_req");
    run(1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, "u1_keep");
    run(1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b01, 2'b10, 1'b0, "u0_iso_only");
    run(4, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, "u0_off_u1_on");
    run(1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 1'b0, "u1_req");
    for (int k = 0; k < 2; k++) begin
      run(6, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, "u0_off_u1_on");
      run(1, 1'b0, 1'b1, 2'b10, 2'b10, 2'b01, 2'b10, 1'b0, "u1_req");
    end

    // Requests without ins_vld neither keep unit 1 alive nor wake it.
    run(8, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 2'b10, 1'b0, "novld_on");
    run(1, 1'b0, 1'b0, 2'b10, 2'b10, 2'b11, 2'b00, 1'b0, "novld_iso");
    run(9, 1'b0, 1'b0, 2'b10, 2'b00, 2'b11, 2'b00, 1'b0, "novld_off");

    // Reset in the middle of WAKE.
    run(1, 1'b0, 1'b1, 2'b01, 2'b00, 2'b11, 2'b00, 1'b1, "f_req");
    run(1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b11, 2'b00, 1'b1, "f_wake0");
    run(1, 1'b1, 1'b1, 2'b01, 2'b01, 2'b11, 2'b00, 1'b1, "f_wake1_rst");
    run(1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b00, 2'b11, 1'b0, "post_rst");

`ifdef PG_PREWAKE_EN
    // Hint wakes an OFF unit without ever stalling.
    run(7, 1'b0, 1'b0, 2'b00, 2'b11, 2'b00, 2'b11, 1'b0, "h_idle");
    run(1, 1'b0, 1'b0, 2'b00, 2'b11, 2'b10, 2'b01, 1'b0, "h_u1_iso");
    run(1, 1'b0, 1'b0, 2'b00, 2'b01, 2'b11, 2'b00, 1'b0, "h_u0_iso");
    run(1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, "h_all_off");
    hint_nxt = 2'b01;
    run(1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 1'b0, "h_hint");
    hint_nxt = 2'b00;
    run(3, 1'b0, 1'b0, 2'b00, 2'b01, 2'b11, 2'b00, 1'b0, "h_wake");
    run(1, 1'b0, 1'b1, 2'b01, 2'b01, 2'b10, 2'b01, 1'b0, "h_on");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
